dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the 5-stage pipeline.
- Serves the MEM-stage load/store (CPU port p1) on hits with zero added latency.
- On a miss, runs a line write-back and refill against off-chip data memory.
- Drives the pipeline stall that freezes PC, IF/ID, ID/EX, EX/MEM and the MEM/WB register until the access completes.

Parameters:
- NUM_LINES, 32, number of cache lines; power of two.
- WORDS_PER_LINE, 8, 32-bit words per line; power of two; memory line width = 32*WORDS_PER_LINE.

Ports:
- Clock_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- p1_req_i  input  1  MEM stage issues a load or store this cycle.
- p1_write_i  input  1  1 = store, 0 = load; valid with p1_req_i.
- p1_addr_i  input  32  byte address; bits [1:0] ignored.
- p1_data_i  input  32  store data.
- p1_data_o  output  32  load data, to MEM/WB MEM_i.
- p1_stall_o  output  1  pipeline stall, to all pipeline registers including MEM/WB stall_i.
- mem_enable_o  output  1  memory request, held until ack.
- mem_write_o  output  1  1 = line write-back, 0 = line read.
- mem_addr_o  output  32  line-aligned byte address.
- mem_data_o  output  32*WORDS_PER_LINE  victim line data.
- mem_data_i  input  32*WORDS_PER_LINE  refill line data.
- mem_ack_i  input  1  one-cycle pulse; transfer complete.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) word-offset bits at [OFF+1:2].
  - IDX = log2(NUM_LINES) index bits above the offset.
  - Tag = remaining upper bits.
- Per line: valid, dirty, tag, data.
- hit = p1_req_i & valid[idx] & (tag[idx] == addr tag), combinational.
- p1_stall_o = (p1_req_i & ~hit) | (state != IDLE), combinational.
- The pipeline holds p1_* stable while stalled.
- Read hit:
  - p1_data_o = selected word, same cycle; no stall.
  - p1_data_o = 0 whenever not (p1_req_i & hit).
- Write hit: on the clock edge, write the selected word with p1_data_i and set dirty = 1; no stall.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
  - IDLE: on p1_req_i & ~hit, go to WRITEBACK if valid & dirty, else ALLOCATE.
  - WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, idx, 0}, mem_data_o = victim line. On mem_ack_i, go to ALLOCATE.
  - ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, idx, 0}. On mem_ack_i, capture mem_data_i, go to REFILL.
  - REFILL:
    - Write the captured line, tag = req tag, valid = 1, dirty = 0.
    - Go to IDLE.
    - The next cycle re-evaluates as a hit: a load returns data and the stall drops; a store merges and sets dirty.
- mem_enable_o and mem_write_o are registered.
- mem_enable_o drops in the cycle after ack is sampled, then re-asserts for ALLOCATE.
- mem_ack_i is ignored in IDLE and REFILL.
- Miss penalty = memory latency(s) + 2 cycles (REFILL + hit cycle).
- Reset, asserted at any time including mid-transaction:
  - state = IDLE, all valid and dirty = 0, mem_enable_o = 0, mem_write_o = 0, p1_stall_o follows the combinational rule.
  - Tag and data arrays need no reset.
  - An in-flight memory transfer is abandoned; the memory model must tolerate enable dropping.
- p1_req_i deasserting while state != IDLE does not happen with a correct pipeline. The FSM still completes the transfer and fills the line.
- Back-to-back accesses to the same line after a refill hit with no further stall.

Decomposition:
- Shared package dcache_pkg holds:
  - FSM state encoding constants (IDLE = 0, WRITEBACK = 1, ALLOCATE = 2, REFILL = 3).
  - WORD_W = 32.
  - Functions or localparams deriving OFF, IDX and TAG widths.
- One sub-module, dcache_sram: tag/valid/dirty/data storage.
  - Asynchronous read, synchronous write.
  - Asynchronous clear of valid and dirty on rst_i.
  - Full-line write for refill, single-word write for stores.

Test Plan:
- Cold read miss:
  - Stimulus: load 0x0000_0040, memory acks after 3 cycles with word1 = 0xDEAD_BEEF.
  - Required: mem_write_o = 0 and mem_addr_o = 0x40; stall high for 3 + 2 cycles; then p1_data_o = 0xDEAD_BEEF and stall low.
- Write hit:
  - Stimulus: store 0x1234_5678 to 0x44 after the first test, then load 0x44.
  - Required: no stall on either access; load returns 0x1234_5678.
- Dirty eviction:
  - Stimulus: load 0x0000_0440, same index 2, different tag.
  - Required: WRITEBACK first with mem_write_o = 1, mem_addr_o = 0x40 and mem_data_o word1 = 0x1234_5678; then ALLOCATE with mem_addr_o = 0x440.
- Write miss on a clean line:
  - Stimulus: store 0xAAAA_0001 to 0x80.
  - Required: no write-back; refill of 0x80; the merged word reads back 0xAAAA_0001; dirty = 1, shown by the next eviction issuing a write-back.
- Reset mid-WRITEBACK:
  - Stimulus: assert rst_i while mem_enable_o = 1.
  - Required: mem_enable_o = 0 immediately; the previously cached address then misses.
- Ack timing:
  - Stimulus: mem_ack_i arrives 1 cycle after enable.
  - Required: mem_enable_o is low in the following cycle; total miss stall = 3 cycles.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // Controller sequencing for a miss: optional victim write-back, line read, line install.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

  // Word-offset bits within a line.
  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Index bits selecting a line.
  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag bits: whatever is left of the byte address above offset and index.
  function automatic int tag_w(input int num_lines, input int words_per_line);
    return WORD_W - BYTE_OFF_W - off_w(words_per_line) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: valid/dirty/tag/data per line.
// Latency: combinational read, writes land on the rising edge of Clock_i.
// Backpressure: none; the controller guarantees fill and word writes never coincide.
//
// Ports:
//   Clock_i, rst_i        clock; async active-high reset clears valid and dirty only
//   rd_idx -> rd_*        asynchronous read of one line (valid, dirty, tag, full data)
//   fill_*                full-line install: tag and data written, valid=1, dirty=0
//   word_*                single-word store into an installed line, sets dirty
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                                 Clock_i,
  input  logic                                 rst_i,
  input  logic [idx_w(NUM_LINES)-1:0]          rd_idx,
  output logic                                 rd_valid,
  output logic                                 rd_dirty,
  output logic [tag_w(NUM_LINES, WORDS_PER_LINE)-1:0] rd_tag,
  output logic [WORD_W*WORDS_PER_LINE-1:0]     rd_line,
  input  logic                                 fill_we,
  input  logic [idx_w(NUM_LINES)-1:0]          fill_idx,
  input  logic [tag_w(NUM_LINES, WORDS_PER_LINE)-1:0] fill_tag,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]     fill_line,
  input  logic                                 word_we,
  input  logic [idx_w(NUM_LINES)-1:0]          word_idx,
  input  logic [off_w(WORDS_PER_LINE)-1:0]     word_off,
  input  logic [WORD_W-1:0]                    word_data
);

  localparam int TAG_W  = tag_w(NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Status bits are the only state that must be clean after reset.
  always_ff @(posedge Clock_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
      if (word_we) begin
        dirty_q[word_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; an invalid line's contents are never observed.
  always_ff @(posedge Clock_i) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_line;
    end
    if (word_we) begin
      data_q[word_idx][WORD_W*int'(word_off) +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM stage.
// Latency: hits are zero-cycle; a miss costs the memory latencies plus REFILL and the hit cycle.
// Backpressure: p1_stall_o freezes the pipeline on a miss; memory handshakes with enable held until ack.
//
// Ports:
//   Clock_i, rst_i              clock; async active-high reset (abandons any memory transfer)
//   p1_req_i/p1_write_i         MEM-stage load/store request, held stable while stalled
//   p1_addr_i/p1_data_i         byte address (bits [1:0] ignored) and store data
//   p1_data_o/p1_stall_o        load data (0 unless a request hits) and pipeline stall
//   mem_enable_o/mem_write_o    registered line request to off-chip memory; write = victim write-back
//   mem_addr_o/mem_data_o       line-aligned address and victim line
//   mem_data_i/mem_ack_i        refill line and one-cycle completion pulse
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                              Clock_i,
  input  logic                              rst_i,
  input  logic                              p1_req_i,
  input  logic                              p1_write_i,
  input  logic [31:0]                       p1_addr_i,
  input  logic [31:0]                       p1_data_i,
  output logic [31:0]                       p1_data_o,
  output logic                              p1_stall_o,
  output logic                              mem_enable_o,
  output logic                              mem_write_o,
  output logic [31:0]                       mem_addr_o,
  output logic [WORD_W*WORDS_PER_LINE-1:0]  mem_data_o,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]  mem_data_i,
  input  logic                              mem_ack_i
);

  localparam int OFF_W      = off_w(WORDS_PER_LINE);
  localparam int IDX_W      = idx_w(NUM_LINES);
  localparam int TAG_W      = tag_w(NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_W     = WORD_W * WORDS_PER_LINE;
  localparam int LINE_OFF_W = OFF_W + BYTE_OFF_W;

  // Address split.
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       unused_byte_sel;

  assign req_off         = p1_addr_i[LINE_OFF_W-1:BYTE_OFF_W];
  assign req_idx         = p1_addr_i[LINE_OFF_W +: IDX_W];
  assign req_tag         = p1_addr_i[WORD_W-1 -: TAG_W];
  assign unused_byte_sel = p1_addr_i[1:0];

  state_t state_q, state_d;
  logic   enable_q, enable_d;
  logic   write_q, write_d;

  // The missing line's index/tag are latched when the miss is taken, so the
  // transfer and the install do not depend on p1_addr_i staying put.
  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [LINE_W-1:0] refill_q;

  logic [IDX_W-1:0]  rd_idx;
  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;

  logic hit;
  logic miss_start;
  logic ack_ok;
  logic word_we;
  logic fill_we;

  // While a miss is in progress the single read port looks at the victim/target line.
  assign rd_idx = (state_q == IDLE) ? req_idx : miss_idx_q;

  dcache_sram #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_sram (
    .Clock_i   (Clock_i),
    .rst_i     (rst_i),
    .rd_idx    (rd_idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_line   (line_data),
    .fill_we   (fill_we),
    .fill_idx  (miss_idx_q),
    .fill_tag  (miss_tag_q),
    .fill_line (refill_q),
    .word_we   (word_we),
    .word_idx  (req_idx),
    .word_off  (req_off),
    .word_data (p1_data_i)
  );

  // Hits are only recognised in IDLE: in any other state the read port points at
  // the line under transfer and the pipeline is frozen anyway.
  assign hit        = p1_req_i & (state_q == IDLE) & line_valid & (line_tag == req_tag);
  assign miss_start = p1_req_i & (state_q == IDLE) & ~hit;
  assign word_we    = hit & p1_write_i;
  assign fill_we    = (state_q == REFILL);

  // An ack only counts against a request that is actually on the bus; this also
  // covers the dead cycle between write-back and allocate.
  assign ack_ok = mem_ack_i & enable_q;

  assign p1_stall_o = (p1_req_i & ~hit) | (state_q != IDLE);
  assign p1_data_o  = hit ? line_data[WORD_W*int'(req_off) +: WORD_W] : '0;

  // Next-state and registered memory-request controls.
  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    write_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_start) begin
          state_d = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (ack_ok) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (ack_ok) state_d = REFILL;
      end
      REFILL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Enable drops for one cycle after every sampled ack, so each transfer is a fresh request.
    enable_d = ((state_d == WRITEBACK) | (state_d == ALLOCATE)) & ~ack_ok;
    write_d  = (state_d == WRITEBACK) & ~ack_ok;
  end

  always_ff @(posedge Clock_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      write_q  <= write_d;
    end
  end

  // Datapath captures; contents are only consumed after being written in this miss.
  always_ff @(posedge Clock_i) begin
    if (miss_start) begin
      miss_idx_q <= req_idx;
      miss_tag_q <= req_tag;
    end
    if ((state_q == ALLOCATE) & ack_ok) begin
      refill_q <= mem_data_i;
    end
  end

  assign mem_enable_o = enable_q;
  assign mem_write_o  = write_q;

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (state_q)
      WRITEBACK: begin
        mem_addr_o = {line_tag, miss_idx_q, {LINE_OFF_W{1'b0}}};
        mem_data_o = line_data;
      end
      ALLOCATE: begin
        mem_addr_o = {miss_tag_q, miss_idx_q, {LINE_OFF_W{1'b0}}};
      end
      default: begin
        mem_addr_o = '0;
        mem_data_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus random accesses against an architectural memory and line-state model.
// Latency: n/a (bench).
// Backpressure: a latency-programmable memory responder acks after N enabled cycles.
module tb_dcache_ctrl;

  localparam int NL  = 32;
  localparam int WPL = 8;
  localparam int LW  = 32 * WPL;

  logic          Clock_i      = 1'b0;
  logic          rst_i        = 1'b1;
  logic          p1_req_i     = 1'b0;
  logic          p1_write_i   = 1'b0;
  logic [31:0]   p1_addr_i    = '0;
  logic [31:0]   p1_data_i    = '0;
  logic [31:0]   p1_data_o;
  logic          p1_stall_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic [LW-1:0] mem_data_i   = '0;
  logic          mem_ack_i    = 1'b0;

  dcache_ctrl #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .Clock_i      (Clock_i),
    .rst_i        (rst_i),
    .p1_req_i     (p1_req_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 Clock_i = ~Clock_i;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [LW-1:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];

  // Off-chip memory contents and the architectural (program-visible) memory.
  logic [31:0] bmem [int unsigned];
  logic [31:0] arch [int unsigned];

  // What the model believes each cache line holds.
  bit          mv [NL];
  bit          md [NL];
  int unsigned mt [NL];

  int lat_wb = 2;
  int lat_al = 2;

  function automatic logic [31:0] dflt(input int unsigned wa);
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] bget(input int unsigned wa);
    return bmem.exists(wa) ? bmem[wa] : dflt(wa);
  endfunction

  function automatic logic [31:0] aget(input int unsigned wa);
    return arch.exists(wa) ? arch[wa] : dflt(wa);
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks in the N-th consecutive enabled cycle.
  int   cnt = 0;
  logic ack_prev;
  always @(posedge Clock_i) begin
    xfer_t x;
    logic [LW-1:0] line;
    #1;
    ack_prev = mem_ack_i;
    if (ack_prev) chk("enable_drop_after_ack", mem_enable_o, 0);
    if (mem_enable_o) begin
      cnt++;
      if (cnt == (mem_write_o ? lat_wb : lat_al)) begin
        x.wr   = mem_write_o;
        x.addr = mem_addr_o;
        if (mem_write_o) begin
          x.data = mem_data_o;
          for (int w = 0; w < WPL; w++) bmem[(mem_addr_o >> 2) + w] = mem_data_o[w*32 +: 32];
        end else begin
          x.data = '0;
          for (int w = 0; w < WPL; w++) line[w*32 +: 32] = bget((mem_addr_o >> 2) + w);
          mem_data_i = line;
        end
        obs_q.push_back(x);
        mem_ack_i = 1'b1;
      end else begin
        mem_ack_i = 1'b0;
      end
    end else begin
      cnt       = 0;
      mem_ack_i = 1'b0;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NL; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = 0;
    end
  endtask

  // One pipeline access, starting just after a rising edge; returns just after the
  // edge on which the access completes, so successive calls are back to back.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned idx = (addr >> 5) % NL;
    int unsigned tag = addr >> 10;
    int unsigned wa  = addr >> 2;
    bit          miss = !(mv[idx] && mt[idx] == tag);
    int          exp_cyc = 0;
    int          cyc = 0;
    bit          done = 0;
    int          n;
    xfer_t       x;
    exp_q.delete();
    obs_q.delete();
    if (miss) begin
      if (mv[idx] && md[idx]) begin
        x.wr   = 1'b1;
        x.addr = (mt[idx] << 10) | (idx << 5);
        for (int w = 0; w < WPL; w++) x.data[w*32 +: 32] = aget((x.addr >> 2) + w);
        exp_q.push_back(x);
        exp_cyc = lat_wb + 1 + lat_al + 2;
      end else begin
        exp_cyc = lat_al + 2;
      end
      x.wr   = 1'b0;
      x.addr = addr & ~32'h1F;
      x.data = '0;
      exp_q.push_back(x);
    end
    p1_req_i   = 1'b1;
    p1_write_i = wr;
    p1_addr_i  = addr;
    p1_data_i  = wd;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock_i);
      if (i == 0 && miss) chk("miss_data_zero", p1_data_o, 0);
      if (!p1_stall_o) begin
        done = 1;
        break;
      end
      cyc++;
    end
    chk("stall_released", done, 1);
    chk("stall_cycles", cyc, exp_cyc);
    if (done && !wr) chk("load_data", p1_data_o, aget(wa));
    @(posedge Clock_i);
    #1;
    p1_req_i   = 1'b0;
    p1_write_i = 1'b0;
    chk("xfer_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("xfer_write", obs_q[i].wr, exp_q[i].wr);
      chk("xfer_addr", obs_q[i].addr, exp_q[i].addr);
      chk("xfer_data", obs_q[i].data, exp_q[i].data);
    end
    if (miss) begin
      mv[idx] = 1'b1;
      mt[idx] = tag;
      md[idx] = 1'b0;
    end
    if (wr) begin
      arch[wa] = wd;
      md[idx]  = 1'b1;
    end
  endtask

  initial begin
    bit found;
    clear_model();

    // Reset state, idle request lines.
    repeat (2) @(posedge Clock_i);
    @(negedge Clock_i);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_stall", p1_stall_o, 0);
    chk("rst_data", p1_data_o, 0);
    @(posedge Clock_i);
    #1;
    rst_i = 1'b0;

    // Cold read miss on line 0x40 with 3-cycle memory, word1 preset.
    bmem[32'h44 >> 2] = 32'hDEAD_BEEF;
    arch[32'h44 >> 2] = 32'hDEAD_BEEF;
    lat_al = 3;
    access(1'b0, 32'h40, '0);
    access(1'b0, 32'h44, '0);

    // Write hit then read-back, both unstalled.
    access(1'b1, 32'h44, 32'h1234_5678);
    access(1'b0, 32'h44, '0);

    // Dirty eviction to the same index with a different tag.
    lat_wb = 2;
    lat_al = 2;
    access(1'b0, 32'h440, '0);

    // Write miss on a clean line, read back, then prove it went dirty.
    access(1'b1, 32'h80, 32'hAAAA_0001);
    access(1'b0, 32'h80, '0);
    access(1'b0, 32'h480, '0);

    // Ack one cycle after enable: three-cycle miss.
    lat_al = 1;
    access(1'b0, 32'h100, '0);

    // Reset while a write-back is on the bus.
    lat_al = 2;
    access(1'b1, 32'hC0, 32'h55AA_55AA);
    lat_wb = 4;
    p1_req_i   = 1'b1;
    p1_write_i = 1'b0;
    p1_addr_i  = 32'h4C0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock_i);
      if (mem_enable_o && mem_write_o) begin
        found = 1;
        break;
      end
    end
    chk("wb_seen_before_reset", found, 1);
    rst_i = 1'b1;
    #1;
    chk("midrst_enable", mem_enable_o, 0);
    chk("midrst_write", mem_write_o, 0);
    chk("midrst_stall", p1_stall_o, 1);
    chk("midrst_data", p1_data_o, 0);
    @(posedge Clock_i);
    #1;
    rst_i    = 1'b0;
    p1_req_i = 1'b0;
    clear_model();
    arch = bmem;
    lat_wb = 2;
    access(1'b0, 32'hC0, '0);

    // Random traffic over a few conflicting tags and indices.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, WPL - 1) << 2);
      lat_wb = $urandom_range(1, 4);
      lat_al = $urandom_range(1, 4);
      access(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
